// File: rtl/fp32_mul_sched.sv
// fp32_mul_sched: shares one pipelined fp32 multiplier among NUM_REQ requesters,
//   using a round-robin grant, a {valid,id} tag pipeline and an in-order response FIFO.
// Latency: an issue in cycle T produces rsp_valid no earlier than T+MUL_LAT+1.
//   Results are returned in issue order.
// Backpressure: an issue needs a credit, so queued + in-flight results must be below
//   FIFO_DEPTH. A pop frees its credit one cycle later. req_ready stays low until then.
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b                packed operands, requester i at [32i+31:32i]
//   mul_a/mul_b/mul_result     shared multiplier (result valid MUL_LAT cycles after operands)
//   rsp_valid/rsp_ready        response handshake; rsp_result/rsp_id = FIFO head
// Option: define FP32_MUL_SCHED_PRIO_EN to give requester 0 absolute priority.
//   The remaining requesters then share grants round-robin.
module fp32_mul_sched #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    input  logic [31:0]                mul_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_result,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [MUL_LAT];
    logic [31:0]      fifo_res_q [FIFO_DEPTH];
    logic [ID_W-1:0]  fifo_id_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, inflight_q, inflight_d;

    logic               credit_ok, issue, push, pop;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] elig;
    int                 idx;

    // Every result already queued or still in the multiplier holds a FIFO slot.
    // Gating with rst_n keeps req_ready low while reset is asserted.
    assign credit_ok = rst_n && (({1'b0, cnt_q} + {1'b0, inflight_q}) < DEPTH_C);

    always_comb begin
        elig   = req_valid;
        issue  = 1'b0;
        gnt_id = '0;
        idx    = 0;
`ifdef FP32_MUL_SCHED_PRIO_EN
        // Requester 0 pre-empts the others. Otherwise it is removed from the search.
        if (req_valid[0]) elig = NUM_REQ'(1);
        else              elig[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!issue && elig[ID_W'(idx)]) begin
                issue  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        issue = issue & credit_ok;
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        rr_ptr_d  = rr_ptr_q;
        if (issue) begin
            req_ready[gnt_id] = 1'b1;
`ifdef FP32_MUL_SCHED_PRIO_EN
            if (gnt_id != '0) rr_ptr_d = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
`else
            rr_ptr_d = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
`endif
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && gnt_id == ID_W'(i)) begin
                mul_a = req_a[i*32 +: 32];
                mul_b = req_b[i*32 +: 32];
            end
        end
    end

    // The last tag stage lines up with mul_result for the same operands.
    assign push      = tag_vld_q[MUL_LAT-1];
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Head data is masked so that stale storage is never visible, including during reset.
    assign rsp_result = rsp_valid ? fifo_res_q[rd_ptr_q] : '0;
    assign rsp_id     = rsp_valid ? fifo_id_q[rd_ptr_q]  : '0;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            tag_vld_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q[0] <= issue;
            for (int i = 1; i < MUL_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Payload storage needs no reset, because every entry is qualified by a valid or a count.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int i = 1; i < MUL_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
        if (push) begin
            fifo_res_q[wr_ptr_q] <= mul_result;
            fifo_id_q[wr_ptr_q]  <= tag_id_q[MUL_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (cnt_q != CNT_W'(FIFO_DEPTH) || pop));
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: doc/fp32_mul_sched.md
FP32_MUL_SCHED -- requirements
Module: fp32_mul_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter MUL_LAT, default 2: cycles from operands driven to fp32 multiplier result valid.
REQ-003 Parameter FIFO_DEPTH, default 4: response FIFO entries (power of 2, >= MUL_LAT+1).
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ: per-requester operand valid.
REQ-007 req_ready  output  NUM_REQ: per-requester grant; at most one bit high per cycle.
REQ-008 req_a, req_b  input  NUM_REQ*32: packed fp32 operands; requester i at bits [32i+31:32i].
REQ-009 mul_a, mul_b  output  32: operands to the shared fp32 multiplier.
REQ-010 mul_result  input  32: fp32 multiplier result.
REQ-011 rsp_valid  output  1: response available.
REQ-012 rsp_ready  input  1: response consumer accept.
REQ-013 rsp_result  output  32: product.
REQ-014 rsp_id  output  clog2(NUM_REQ): originating requester index.

Function
REQ-015 Issue occurs in cycle T when req_valid[i] & req_ready[i]; req_ready combinational from req_valid, arbiter pointer, credit state.
REQ-016 mul_a/mul_b = granted requester's operands in issue cycle, else 32'h0.
REQ-017 Arbitration round-robin: search starts at rr_ptr; after issue to i, rr_ptr <= (i+1) mod NUM_REQ; unchanged when no issue.
REQ-018 Tag pipeline of MUL_LAT stages carries {valid, id}; mul_result sampled at end of cycle T+MUL_LAT and pushed into FIFO with id.
REQ-019 Credit rule: issue allowed only if fifo_count + inflight_count < FIFO_DEPTH; a pop in cycle T frees credit from T+1 only.
REQ-020 FIFO never overflows; push with full is impossible by REQ-019 (assertion-checked).
REQ-021 rsp_valid = FIFO non-empty; rsp_result/rsp_id = head entry; pop on rsp_valid & rsp_ready.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; pop of empty FIFO ignored.
REQ-023 Minimum latency issue-to-rsp_valid = MUL_LAT+1 cycles; responses delivered in issue order.
REQ-024 Sustained throughput one issue per cycle while rsp_ready held high and any req_valid high.
REQ-025 Operands pass unmodified; special values (NaN, Inf, zero, denormal) are multiplier responsibility.
REQ-026 Pointers wrap modulo FIFO_DEPTH; counters sized to hold FIFO_DEPTH without wrap.

Reset
REQ-027 On rst_n low: rr_ptr=0, tag pipeline valids=0, FIFO pointers/count=0, inflight_count=0, immediately and asynchronously.
REQ-028 During reset: req_ready=0, rsp_valid=0, rsp_result=0, rsp_id=0, mul_a=mul_b=0.
REQ-029 Reset mid-operation discards in-flight and queued results; no response after deassertion without a new issue.
REQ-030 First issue possible in first cycle after rst_n deasserts.

Configuration
REQ-031 Macro FP32_MUL_SCHED_PRIO_EN defined: requester 0 wins whenever req_valid[0] and credit available; rr_ptr updates only on issues to requesters 1..NUM_REQ-1, round-robin among them.
REQ-032 Macro undefined: pure round-robin across all requesters per REQ-017.

Verification
REQ-033 Req0 a=0x40000000, b=0x40400000 single issue -> rsp_valid at T+3, rsp_result=0x40C00000, rsp_id=0.
REQ-034 All four req_valid held, rsp_ready=1, 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle; 8 responses in order (macro off).
REQ-035 rsp_ready=0, continuous requests -> exactly 4 issues, then req_ready=0 all; rsp_ready=1 -> one issue resumes cycle after first pop.
REQ-036 Req2 a=b=0x3FC00000 with simultaneous pop and push in same cycle -> count stable, result 0x40100000, id 2.
REQ-037 rst_n pulsed low with 2 in flight, 2 queued -> rsp_valid=0 immediately, no stale response afterward.
REQ-038 FP32_MUL_SCHED_PRIO_EN defined, req0 and req1 always valid -> req0 granted every cycle, req1 never while credit permits.
